// File: rtl/md_pkg.sv
// md_pkg: shared definitions for the multiply/divide unit, its controller and
// the hazard unit.
//   md_op_e    : operation code presented on md_unit.op
//   md_state_e : md_unit sequencing state (IDLE / RUN)
//   MD_*       : default width, latencies and counter width
//   md_is_long : true for operations that occupy the unit for several cycles
package md_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam int MD_WIDTH       = 32;
    localparam int MD_MULT_CYCLES = 5;
    localparam int MD_DIV_CYCLES  = 10;
    localparam int MD_CNT_W       = 4;

    // Multiply and divide occupy the unit; MTHI/MTLO complete in one edge.
    function automatic logic md_is_long(input logic [2:0] op);
        logic res;
        case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: res = 1'b1;
            default:                            res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/md_divider.sv
// md_divider: combinational signed/unsigned divide/remainder core.
//   dividend, divisor : WIDTH-bit operands
//   is_signed         : 1 = two's-complement DIV semantics, 0 = DIVU
//   quotient          : truncated toward zero
//   remainder         : carries the sign of the dividend
//   div_zero          : divisor was zero (quotient/remainder are 0 then)
// The signed case works on magnitudes; MIN / -1 needs no special path because
// |MIN| is representable as an unsigned WIDTH-bit value and the quotient sign
// is positive, which wraps back to MIN with a zero remainder.
module md_divider
    import md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             is_signed,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    logic             neg_a_s;
    logic             neg_b_s;
    logic [WIDTH-1:0] mag_a_s;
    logic [WIDTH-1:0] mag_b_s;
    logic [WIDTH-1:0] q_mag_s;
    logic [WIDTH-1:0] r_mag_s;
    logic             zero_s;

    // Magnitude divide followed by sign restoration
    always_comb begin
        neg_a_s = is_signed & dividend[WIDTH-1];
        neg_b_s = is_signed & divisor[WIDTH-1];
        mag_a_s = neg_a_s ? (~dividend + WIDTH'(1)) : dividend;
        mag_b_s = neg_b_s ? (~divisor + WIDTH'(1)) : divisor;
        zero_s  = (divisor == {WIDTH{1'b0}});
        if (zero_s) begin
            q_mag_s = {WIDTH{1'b0}};
            r_mag_s = {WIDTH{1'b0}};
        end else begin
            q_mag_s = mag_a_s / mag_b_s;
            r_mag_s = mag_a_s % mag_b_s;
        end
    end

    assign quotient  = (neg_a_s ^ neg_b_s) ? (~q_mag_s + WIDTH'(1)) : q_mag_s;
    assign remainder = neg_a_s ? (~r_mag_s + WIDTH'(1)) : r_mag_s;
    assign div_zero  = zero_s;

endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers (E stage).
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   start, op  : operation valid this cycle and its md_op_e code
//   a, b       : forwarded rs / rt operands
//   cancel     : abort the in-flight operation, HI/LO keep pre-op values
//   busy       : a multiply/divide is in flight (registered)
//   hi, lo     : architectural HI/LO registers
// The result is computed at the accepting edge into pending registers and is
// only copied into HI/LO after the fixed latency, so a cancel or reset during
// the busy window never exposes a partial or speculative result.
module md_unit
    import md_pkg::*;
#(
    parameter int WIDTH       = MD_WIDTH,
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES,
    parameter int CNT_W       = MD_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    md_state_e          state_r;
    md_state_e          state_nxt_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt_s;
    logic               busy_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic [WIDTH-1:0]   pend_hi_r;
    logic [WIDTH-1:0]   pend_lo_r;
    logic               pend_we_r;

    logic               load_mul_s;
    logic               load_div_s;
    logic               commit_s;
    logic               mthi_s;
    logic               mtlo_s;

    logic [2*WIDTH-1:0] ext_a_s;
    logic [2*WIDTH-1:0] ext_b_s;
    logic [2*WIDTH-1:0] prod_s;
    logic               mul_signed_s;
    logic               div_signed_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;
    logic               dz_s;

    // Operands are sign- or zero-extended to 2*WIDTH so one truncated
    // product serves both MULT and MULTU.
    assign mul_signed_s = (op == MD_MULT);
    assign div_signed_s = (op == MD_DIV);
    assign ext_a_s = mul_signed_s ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    assign ext_b_s = mul_signed_s ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    assign prod_s  = ext_a_s * ext_b_s;

    md_divider #(
        .WIDTH (WIDTH)
    ) u_div (
        .dividend  (a),
        .divisor   (b),
        .is_signed (div_signed_s),
        .quotient  (quo_s),
        .remainder (rem_s),
        .div_zero  (dz_s)
    );

    // Next-state, counter and datapath-enable decode
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        load_mul_s  = 1'b0;
        load_div_s  = 1'b0;
        commit_s    = 1'b0;
        mthi_s      = 1'b0;
        mtlo_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // cancel has no meaning here; only start is decoded.
                if (start) begin
                    case (op)
                        MD_MULT, MD_MULTU: begin
                            load_mul_s  = 1'b1;
                            cnt_nxt_s   = CNT_W'(MULT_CYCLES - 1);
                            state_nxt_s = ST_RUN;
                        end
                        MD_DIV, MD_DIVU: begin
                            load_div_s  = 1'b1;
                            cnt_nxt_s   = CNT_W'(DIV_CYCLES - 1);
                            state_nxt_s = ST_RUN;
                        end
                        MD_MTHI: mthi_s = 1'b1;
                        MD_MTLO: mtlo_s = 1'b1;
                        default: begin
                            state_nxt_s = ST_IDLE;
                        end
                    endcase
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                // start is ignored while running; cancel beats completion.
                if (cancel) begin
                    state_nxt_s = ST_IDLE;
                    cnt_nxt_s   = {CNT_W{1'b0}};
                end else if (cnt_r == {CNT_W{1'b0}}) begin
                    commit_s    = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    cnt_nxt_s   = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // FSM state, latency counter and registered busy flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            busy_r  <= (state_nxt_s == ST_RUN);
        end
    end

    // Pending result capture and HI/LO update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_hi_r <= {WIDTH{1'b0}};
            pend_lo_r <= {WIDTH{1'b0}};
            pend_we_r <= 1'b0;
            hi_r      <= {WIDTH{1'b0}};
            lo_r      <= {WIDTH{1'b0}};
        end else begin
            if (load_mul_s) begin
                pend_hi_r <= prod_s[2*WIDTH-1:WIDTH];
                pend_lo_r <= prod_s[WIDTH-1:0];
                pend_we_r <= 1'b1;
            end else if (load_div_s) begin
                // Divide by zero still runs the full latency but writes nothing.
                pend_hi_r <= rem_s;
                pend_lo_r <= quo_s;
                pend_we_r <= ~dz_s;
            end
            if (commit_s && pend_we_r) begin
                hi_r <= pend_hi_r;
                lo_r <= pend_lo_r;
            end else begin
                if (mthi_s) begin
                    hi_r <= a;
                end
                if (mtlo_s) begin
                    lo_r <= a;
                end
            end
        end
    end

    assign busy = busy_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed table, hand-written corner sequences and randomized
// operations checked against an arithmetic reference model of md_unit.
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_vec;
    int n_bad;

    logic [31:0] mh;
    logic [31:0] ml;

    md_unit dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .cancel (cancel),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          exp_busy;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: applies one operation to (h,l) and reports latency.
    function automatic void model(input logic [2:0] o, input logic [31:0] x,
                                  input logic [31:0] y, inout logic [31:0] h,
                                  inout logic [31:0] l, output int n);
        longint          sp;
        longint          sq;
        longint          sr;
        longint unsigned up;
        n = 0;
        case (o)
            3'd0: begin
                sp = longint'($signed(x)) * longint'($signed(y));
                h = sp[63:32]; l = sp[31:0]; n = 5;
            end
            3'd1: begin
                up = longint'(x) * longint'(y);
                h = up[63:32]; l = up[31:0]; n = 5;
            end
            3'd2: begin
                n = 10;
                if (y != 32'd0) begin
                    sq = longint'($signed(x)) / longint'($signed(y));
                    sr = longint'($signed(x)) % longint'($signed(y));
                    l = sq[31:0]; h = sr[31:0];
                end
            end
            3'd3: begin
                n = 10;
                if (y != 32'd0) begin
                    l = x / y; h = x % y;
                end
            end
            3'd4: h = x;
            3'd5: l = x;
            default: n = 0;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] o, input logic [31:0] x,
                          input logic [31:0] y, output int nb);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(negedge clk);
        start = 1'b0;
        nb = 0;
        while (busy && nb < 40) begin
            nb++;
            @(negedge clk);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int nb;
        int en;
        int rsel;
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        n_vec = 0; n_bad = 0;
        reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0; cancel = 1'b0;

        tbl[0]  = '{3'd0, 32'd5,          32'hFFFFFFFD, 5,  32'hFFFFFFFF, 32'hFFFFFFF1};
        tbl[1]  = '{3'd3, 32'd7,          32'd2,        10, 32'd1,        32'd3};
        tbl[2]  = '{3'd2, 32'hFFFFFFF9,   32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        tbl[3]  = '{3'd2, 32'h80000000,   32'hFFFFFFFF, 10, 32'd0,        32'h80000000};
        tbl[4]  = '{3'd4, 32'h00001234,   32'd0,        0,  32'h00001234, 32'h80000000};
        tbl[5]  = '{3'd3, 32'd5,          32'd0,        10, 32'h00001234, 32'h80000000};
        tbl[6]  = '{3'd5, 32'd9,          32'd0,        0,  32'h00001234, 32'd9};
        tbl[7]  = '{3'd1, 32'hFFFFFFFF,   32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'd1};
        tbl[8]  = '{3'd0, 32'hFFFFFFFF,   32'hFFFFFFFF, 5,  32'd0,        32'd1};
        tbl[9]  = '{3'd2, 32'd7,          32'hFFFFFFFE, 10, 32'd1,        32'hFFFFFFFD};
        tbl[10] = '{3'd6, 32'hAAAA5555,   32'd3,        0,  32'd1,        32'hFFFFFFFD};

        // Reset state
        @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Directed table
        for (int i = 0; i < 11; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, nb);
            chk($sformatf("tbl%0d_busy", i), nb, tbl[i].exp_busy);
            chk($sformatf("tbl%0d_hi", i), hi, tbl[i].exp_hi);
            chk($sformatf("tbl%0d_lo", i), lo, tbl[i].exp_lo);
        end
        mh = 32'd1; ml = 32'hFFFFFFFD;

        // MULTU 3*4 with an MTLO attempted in busy cycle 2
        @(negedge clk);
        start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd4;
        @(negedge clk);
        start = 1'b0; nb = 0;
        while (busy && nb < 40) begin
            nb++;
            if (nb == 2) begin
                start = 1'b1; op = 3'd5; a = 32'd9;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("mtlo_busy_busycnt", nb, 32'd5);
        chk("mtlo_busy_hi", hi, 32'd0);
        chk("mtlo_busy_lo", lo, 32'd12);
        mh = 32'd0; ml = 32'd12;

        // Cancel in busy cycle 3 of a DIV
        @(negedge clk);
        start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
        @(negedge clk);
        start = 1'b0; nb = 0;
        while (busy && nb < 40) begin
            nb++;
            if (nb == 3) cancel = 1'b1;
            @(negedge clk);
        end
        cancel = 1'b0;
        chk("cancel_busycnt", nb, 32'd3);
        chk("cancel_hi", hi, mh);
        chk("cancel_lo", lo, ml);

        // cancel in IDLE must not block MTHI
        cancel = 1'b1;
        run_op(3'd4, 32'h0000CAFE, 32'd0, nb);
        cancel = 1'b0;
        mh = 32'h0000CAFE;
        chk("idle_cancel_busy", nb, 32'd0);
        chk("idle_cancel_hi", hi, mh);
        chk("idle_cancel_lo", lo, ml);

        // Randomized operations against the model
        for (int i = 0; i < 150; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            rsel = $urandom_range(0, 9);
            if (rsel == 0) rb = 32'd0;
            else if (rsel == 1) rb = 32'hFFFFFFFF;
            else if (rsel == 2) rb = 32'($urandom_range(1, 15));
            if ($urandom_range(0, 9) == 0) ra = 32'h80000000;
            model(ro, ra, rb, mh, ml, en);
            run_op(ro, ra, rb, nb);
            chk($sformatf("rnd%0d_op%0d_busy", i, ro), nb, en);
            chk($sformatf("rnd%0d_op%0d_hi", i, ro), hi, mh);
            chk($sformatf("rnd%0d_op%0d_lo", i, ro), lo, ml);
        end

        // Asynchronous reset in the middle of a MULT
        run_op(3'd4, 32'h0000DEAD, 32'd0, nb);
        @(negedge clk);
        start = 1'b1; op = 3'd0; a = 32'd1234; b = 32'd5678;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("midreset_pre_busy", {31'd0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("midreset_busy", {31'd0, busy}, 32'd0);
        chk("midreset_hi", hi, 32'd0);
        chk("midreset_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op(3'd0, 32'd2, 32'd3, nb);
        chk("post_reset_busy", nb, 32'd5);
        chk("post_reset_hi", hi, 32'd0);
        chk("post_reset_lo", lo, 32'd6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
